// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Multi-cycle control front end for the 8-bit ALU. It accepts one request
//   per start/ready handshake. It then walks IDLE -> LDX -> EXE -> WB, or
//   IDLE -> ERR for an unsupported op. Along the way it drives the register
//   file read port, the X latch load, the ALU function code and the writeback
//   strobe. It also keeps the Z/N flags of the last written result.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   start/ready             request handshake, ready only in IDLE
//   op, src_a, src_b, dst   request fields, sampled at accept
//   bus_sel, bus_oe         register-file read select / output enable
//   x_ld                    load X latch from bus at the next edge
//   alus                    ALU function code, nonzero only in EXE
//   alu_dout                combinational ALU result
//   wr_en, wr_addr, wr_data register-file writeback
//   done, illegal           completion / unsupported-op pulses
//   flag_z, flag_n          zero / negative of the last written result
module alu_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int RA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ready,
    input  logic [3:0]        op,
    input  logic [RA_W-1:0]   src_a,
    input  logic [RA_W-1:0]   src_b,
    input  logic [RA_W-1:0]   dst,
    output logic [RA_W-1:0]   bus_sel,
    output logic              bus_oe,
    output logic              x_ld,
    output logic [3:0]        alus,
    input  logic [DATA_W-1:0] alu_dout,
    output logic              wr_en,
    output logic [RA_W-1:0]   wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              done,
    output logic              illegal,
    output logic              flag_z,
    output logic              flag_n
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDX  = 3'd1;
    localparam logic [2:0] S_EXE  = 3'd2;
    localparam logic [2:0] S_WB   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [3:0] OP_MAX = 4'd8;  // XOR is the highest legal code

    logic [2:0]        state_q, state_d;
    logic [3:0]        op_q;
    logic [RA_W-1:0]   src_a_q, src_b_q, dst_q;
    logic [DATA_W-1:0] result_q;
    logic              flag_z_q, flag_n_q;
    logic              accept;

    assign accept = start && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = (op <= OP_MAX) ? S_LDX : S_ERR;
            S_LDX:   state_d = S_EXE;
            S_EXE:   state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            result_q <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q    <= op;
                src_a_q <= src_a;
                src_b_q <= src_b;
                dst_q   <= dst;
            end
            if (state_q == S_EXE) result_q <= alu_dout;
            // Flags track what was actually written, so they move only in WB.
            if (state_q == S_WB) begin
                flag_z_q <= (result_q == '0);
                flag_n_q <= result_q[DATA_W-1];
            end
        end
    end

    // All control outputs decode from state alone. A reset therefore drops
    // them at once, without waiting for a clock edge.
    assign ready   = (state_q == S_IDLE);
    assign x_ld    = (state_q == S_LDX);
    assign bus_oe  = (state_q == S_LDX) || (state_q == S_EXE);
    assign bus_sel = (state_q == S_LDX) ? src_a_q :
                     (state_q == S_EXE) ? src_b_q : '0;
    assign alus    = (state_q == S_EXE) ? op_q : 4'd0;
    assign wr_en   = (state_q == S_WB);
    assign wr_addr = (state_q == S_WB) ? dst_q : '0;
    assign wr_data = result_q;
    assign done    = (state_q == S_WB) || (state_q == S_ERR);
    assign illegal = (state_q == S_ERR);
    assign flag_z  = flag_z_q;
    assign flag_n  = flag_n_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. The environment is a 4-entry register file,
// an X latch and a combinational ALU around the sequencer. Expected writebacks
// are queued when a request is driven. A monitor pops and compares them on
// every wr_en.
module tb_alu_op_sequencer;

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk, rst_n, start, ready;
    logic [3:0] op, alus;
    logic [1:0] src_a, src_b, dst, bus_sel, wr_addr;
    logic       bus_oe, x_ld, wr_en, done, illegal, flag_z, flag_n;
    logic [7:0] alu_dout, wr_data;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    // environment: register file, X latch, ALU
    logic [7:0] regs [4];
    logic [7:0] exp_regs [4];
    logic [7:0] xl, bus;
    logic       pre_we;
    logic [1:0] pre_addr;
    logic [7:0] pre_data;

    function automatic logic [7:0] alu_ref(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        case (f)
            4'd1: alu_ref = a + b;
            4'd2: alu_ref = a - b;
            4'd3: alu_ref = a + 8'd1;
            4'd4: alu_ref = a - 8'd1;
            4'd5: alu_ref = a & b;
            4'd6: alu_ref = a | b;
            4'd7: alu_ref = ~a;
            4'd8: alu_ref = a ^ b;
            default: alu_ref = 8'h00;
        endcase
    endfunction

    assign bus = bus_oe ? regs[bus_sel] : 8'h00;
    assign alu_dout = alu_ref(alus, xl, bus);

    always @(posedge clk) begin
        if (x_ld) xl <= bus;
        if (wr_en) regs[wr_addr] <= wr_data;
        else if (pre_we) regs[pre_addr] <= pre_data;
    end

    alu_op_sequencer #(.DATA_W(8), .RA_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
        .op(op), .src_a(src_a), .src_b(src_b), .dst(dst),
        .bus_sel(bus_sel), .bus_oe(bus_oe), .x_ld(x_ld), .alus(alus),
        .alu_dout(alu_dout), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .illegal(illegal), .flag_z(flag_z), .flag_n(flag_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // writeback monitor: every wr_en must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && wr_en) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: wr_en with addr=%0d data=%02h, none expected", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data || done !== 1'b1) begin
                    errors++;
                    $display("FAIL wb_data: got addr=%0d data=%02h done=%b, expected addr=%0d data=%02h done=1",
                             wr_addr, wr_data, done, e.addr, e.data);
                end
            end
        end
    end

    task automatic set_reg(input logic [1:0] a, input logic [7:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b after 20 cycles, expected 1", ready);
        end
    endtask

    // Drive one request. The accept edge is the posedge that follows.
    task automatic issue(input logic [3:0] o, input logic [1:0] a, input logic [1:0] b, input logic [1:0] d);
        wait_ready();
        start = 1'b1; op = o; src_a = a; src_b = b; dst = d;
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'hF; src_a = 2'd3; src_b = 2'd3; dst = 2'd3;
    endtask

    // Legal op with a full per-cycle walk and a flag check after WB.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [1:0] a, input logic [1:0] b,
                          input logic [1:0] d, input logic [7:0] ed);
        exp_t e;
        e.addr = d; e.data = ed;
        sb.push_back(e);
        issue(o, a, b, d);
        @(negedge clk);  // LDX
        checks++;
        if (x_ld !== 1'b1 || bus_oe !== 1'b1 || bus_sel !== a || alus !== 4'd0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_ldx: x_ld=%b oe=%b sel=%0d alus=%h ready=%b, expected 1 1 %0d 0 0",
                     nm, x_ld, bus_oe, bus_sel, alus, ready, a);
        end
        @(negedge clk);  // EXE
        checks++;
        if (alus !== o || bus_oe !== 1'b1 || bus_sel !== b || x_ld !== 1'b0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL %s_exe: alus=%h oe=%b sel=%0d x_ld=%b wr_en=%b, expected %h 1 %0d 0 0",
                     nm, alus, bus_oe, bus_sel, x_ld, wr_en, o, b);
        end
        @(negedge clk);  // WB, data compared by the monitor
        checks++;
        if (wr_en !== 1'b1 || done !== 1'b1 || illegal !== 1'b0 || alus !== 4'd0) begin
            errors++;
            $display("FAIL %s_wb: wr_en=%b done=%b illegal=%b alus=%h, expected 1 1 0 0", nm, wr_en, done, illegal, alus);
        end
        @(negedge clk);  // k+4
        checks++;
        if (ready !== 1'b1 || flag_z !== (ed == 8'h00) || flag_n !== ed[7] || done !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: ready=%b z=%b n=%b done=%b, expected 1 %b %b 0",
                     nm, ready, flag_z, flag_n, done, (ed == 8'h00), ed[7]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if (ready !== 1'b1 || {bus_sel, bus_oe, x_ld, alus, wr_en, wr_addr, wr_data, done, illegal, flag_z, flag_n} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b alus=%h wr_en=%b wr_data=%02h done=%b z=%b n=%b, expected ready=1 rest 0",
                     ready, alus, wr_en, wr_data, done, flag_z, flag_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        set_reg(2'd0, 8'h12);
        set_reg(2'd1, 8'h34);
        run_op("add", 4'd1, 2'd0, 2'd1, 2'd2, 8'h46);
    endtask

    task automatic test_wrap();
        set_reg(2'd0, 8'hFF);
        set_reg(2'd1, 8'h01);
        run_op("add_wrap", 4'd1, 2'd0, 2'd1, 2'd2, 8'h00);
        run_op("sub_wrap", 4'd2, 2'd2, 2'd1, 2'd3, 8'hFF);
    endtask

    task automatic test_unary();
        set_reg(2'd3, 8'h7F);
        run_op("inc", 4'd3, 2'd3, 2'd0, 2'd3, 8'h80);
        @(negedge clk);
        checks++;
        if (regs[3] !== 8'h80) begin
            errors++;
            $display("FAIL inc_r3: R3=%02h, expected 80", regs[3]);
        end
        set_reg(2'd1, 8'h0F);
        run_op("not", 4'd7, 2'd1, 2'd2, 2'd0, 8'hF0);
    endtask

    task automatic test_illegal();
        logic z0, n0;
        z0 = flag_z; n0 = flag_n;
        issue(4'b1011, 2'd0, 2'd1, 2'd2);
        @(negedge clk);
        checks++;
        if (illegal !== 1'b1 || done !== 1'b1 || wr_en !== 1'b0 || ready !== 1'b0 || bus_oe !== 1'b0) begin
            errors++;
            $display("FAIL illegal_err: illegal=%b done=%b wr_en=%b ready=%b oe=%b, expected 1 1 0 0 0",
                     illegal, done, wr_en, ready, bus_oe);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b1 || illegal !== 1'b0 || done !== 1'b0 || flag_z !== z0 || flag_n !== n0) begin
            errors++;
            $display("FAIL illegal_after: ready=%b illegal=%b done=%b z=%b n=%b, expected 1 0 0 %b %b",
                     ready, illegal, done, flag_z, flag_n, z0, n0);
        end
    endtask

    // start held high with a new op every cycle: only every 4th is taken
    task automatic test_back_to_back();
        logic [3:0] tbl [12];
        int n;
        tbl = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd8, 4'd3, 4'd4, 4'd7, 4'd0, 4'd1, 4'd2, 4'd5};
        wait_ready();
        for (int i = 0; i < 4; i++) exp_regs[i] = regs[i];
        for (int i = 0; i < 12; i++) begin
            logic [1:0] a, b, d;
            a = 2'(i); b = 2'(i + 1); d = 2'(i + 2);
            start = 1'b1; op = tbl[i]; src_a = a; src_b = b; dst = d;
            #1;
            checks++;
            if (ready !== (i % 4 == 0)) begin
                errors++;
                $display("FAIL b2b_ready: cycle %0d ready=%b, expected %b", i, ready, (i % 4 == 0));
            end
            if (i % 4 == 0) begin
                exp_t e;
                e.addr = d;
                e.data = alu_ref(tbl[i], exp_regs[a], exp_regs[b]);
                exp_regs[d] = e.data;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        start = 1'b0;
        n = 0;
        while ((sb.size() != 0 || ready !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d writebacks outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        set_reg(2'd0, 8'hAA);
        set_reg(2'd1, 8'h0F);
        issue(4'd5, 2'd0, 2'd1, 2'd2);  // no expectation queued: any wr_en fails
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (alus !== 4'd5) begin
            errors++;
            $display("FAIL rstmid_exe: alus=%h, expected 5", alus);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || {bus_sel, bus_oe, x_ld, alus, wr_en, wr_addr, wr_data, done, illegal, flag_z, flag_n} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: ready=%b alus=%h oe=%b wr_en=%b wr_data=%02h n=%b, expected ready=1 rest 0",
                     ready, alus, bus_oe, wr_en, wr_data, flag_n);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== 1'b0 || ready !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_idle: cycle %0d wr_en=%b ready=%b, expected 0 1", i, wr_en, ready);
            end
        end
        checks++;
        if (regs[2] === 8'h0A) begin
            errors++;
            $display("FAIL rstmid_write: R2=%02h, aborted AND must not write", regs[2]);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 4'd0; src_a = 2'd0; src_b = 2'd0; dst = 2'd0;
        pre_we = 1'b0; pre_addr = 2'd0; pre_data = 8'h00;
        xl = 8'h00;
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        test_reset();
        test_add();
        test_wrap();
        test_unary();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_empty: %0d expectations left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
